// File: rtl/wrp_seq_pkg.sv
// Shared sequencing definitions for the push-button conditioning chain:
// FSM state encoding and default debounce/synchronizer settings.
package wrp_seq_pkg;

   typedef logic [1:0] seq_state_t;

   localparam seq_state_t ST_IDLE_LO = 2'd0;
   localparam seq_state_t ST_WAIT_HI = 2'd1;
   localparam seq_state_t ST_IDLE_HI = 2'd2;
   localparam seq_state_t ST_WAIT_LO = 2'd3;

   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/pushbutton_debounce_pulse_if.sv
// Button-side signal bundle: raw button in, toggle pulse / level / busy out.
interface pushbutton_debounce_pulse_if;

   logic btn;
   logic t_pulse;
   logic level;
   logic busy;

   modport master (output btn, input t_pulse, input level, input busy);
   modport slave  (input btn, output t_pulse, output level, output busy);

endinterface

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input; STAGES must be 2..4.
module sync_ff_chain #(
   parameter int STAGES = 2
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pushbutton_debounce_pulse.sv
// Debounces a raw push-button and emits a one-cycle toggle pulse per accepted press
// (and optionally per accepted release), plus the debounced level and a busy flag.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE_LO | button stable released, level = 0
//   ST_WAIT_HI | qualifying a press, counting identical high samples
//   ST_IDLE_HI | button stable pressed, level = 1
//   ST_WAIT_LO | qualifying a release, counting identical low samples
module pushbutton_debounce_pulse
   import wrp_seq_pkg::*;
#(
   parameter int SYNC_STAGES      = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
   parameter bit PULSE_ON_RELEASE = 1'b0
) (
   input  logic input_clock1_clk_1,
   input  logic input_input_switch2__rst_n_2,
   input  logic input_push_button3_btn_3,
   output logic output_led1_t_pulse_4,
   output logic output_led2_level_5,
   output logic output_led3_busy_6
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // Down-counter: entering WAIT counts as the first matching sample, so the
   // remaining samples before terminal count are DEBOUNCE_CYCLES-2.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic             btn_s;
   seq_state_t       state_q;
   seq_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             level_d;
   logic             pulse_q;
   logic             pulse_d;
   logic             busy;

   sync_ff_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync_btn (
      .clk_sys (input_clock1_clk_1),
      .rst_b   (input_input_switch2__rst_n_2),
      .d       (input_push_button3_btn_3),
      .q       (btn_s)
   );

   always_ff @(posedge input_clock1_clk_1 or negedge input_input_switch2__rst_n_2) begin
      if (!input_input_switch2__rst_n_2) begin
         state_q <= ST_IDLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE_LO: begin
            if (btn_s) begin
               state_d = ST_WAIT_HI;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_WAIT_HI: begin
            if (!btn_s) begin
               state_d = ST_IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_IDLE_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_IDLE_HI: begin
            if (!btn_s) begin
               state_d = ST_WAIT_LO;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_WAIT_LO: begin
            if (btn_s) begin
               state_d = ST_IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_IDLE_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // Level tracks the last accepted stable value, so it holds through WAIT_* states.
   always_comb begin
      busy    = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
      level_d = (state_d == ST_IDLE_HI) || (state_d == ST_WAIT_LO);
      pulse_d = ((state_q == ST_WAIT_HI) && (state_d == ST_IDLE_HI))
             || (PULSE_ON_RELEASE && (state_q == ST_WAIT_LO) && (state_d == ST_IDLE_LO));
   end

   assign output_led1_t_pulse_4 = pulse_q;
   assign output_led2_level_5   = level_q;
   assign output_led3_busy_6    = busy;

endmodule

// File: tb/tb_pushbutton_debounce_pulse.sv
// Directed bench for pushbutton_debounce_pulse with SYNC_STAGES=2, DEBOUNCE_CYCLES=4;
// one instance presses only, a second also pulses on release, and a T flip-flop follows the first.
module tb_pushbutton_debounce_pulse;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic raw = 1'b0;
   logic tff_q;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cnt_a;
   int   cnt_b;
   logic prev_a;
   logic prev_b;
   logic [3:0] q_seq;

   always #5 clk = ~clk;

   pushbutton_debounce_pulse_if if_a ();
   pushbutton_debounce_pulse_if if_b ();

   assign if_a.btn = raw;
   assign if_b.btn = raw;

   pushbutton_debounce_pulse #(
      .SYNC_STAGES      (2),
      .DEBOUNCE_CYCLES  (4),
      .PULSE_ON_RELEASE (1'b0)
   ) dut_a (
      .input_clock1_clk_1           (clk),
      .input_input_switch2__rst_n_2 (rst_n),
      .input_push_button3_btn_3     (if_a.btn),
      .output_led1_t_pulse_4        (if_a.t_pulse),
      .output_led2_level_5          (if_a.level),
      .output_led3_busy_6           (if_a.busy)
   );

   pushbutton_debounce_pulse #(
      .SYNC_STAGES      (2),
      .DEBOUNCE_CYCLES  (4),
      .PULSE_ON_RELEASE (1'b1)
   ) dut_b (
      .input_clock1_clk_1           (clk),
      .input_input_switch2__rst_n_2 (rst_n),
      .input_push_button3_btn_3     (if_b.btn),
      .output_led1_t_pulse_4        (if_b.t_pulse),
      .output_led2_level_5          (if_b.level),
      .output_led3_busy_6           (if_b.busy)
   );

   // Downstream T flip-flop fed by the press-only pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tff_q <= 1'b0;
      else if (if_a.t_pulse) tff_q <= ~tff_q;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      raw   = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      // reset state
      rst_n = 1'b0;
      raw   = 1'b1;
      tick();
      tick();
      chk("rst_pulse_a", 32'(if_a.t_pulse), 0);
      chk("rst_level_a", 32'(if_a.level), 0);
      chk("rst_busy_a",  32'(if_a.busy), 0);
      chk("rst_pulse_b", 32'(if_b.t_pulse), 0);
      chk("rst_level_b", 32'(if_b.level), 0);
      chk("rst_tff",     32'(tff_q), 0);

      // 1: clean press held from edge 0
      do_reset();
      for (int e = 0; e < 8; e++) begin
         raw = 1'b1;
         tick();
         chk($sformatf("t1_pulse_e%0d", e), 32'(if_a.t_pulse), 32'(e == 5));
         chk($sformatf("t1_level_e%0d", e), 32'(if_a.level),   32'(e >= 5));
         chk($sformatf("t1_busy_e%0d", e),  32'(if_a.busy),    32'(e >= 2 && e <= 4));
      end

      // 2: bouncing input never qualifies
      do_reset();
      for (int e = 0; e < 14; e++) begin
         raw = (e < 8) && (e % 2 == 0);
         tick();
         chk($sformatf("t2_pulse_a_e%0d", e), 32'(if_a.t_pulse), 0);
         chk($sformatf("t2_pulse_b_e%0d", e), 32'(if_b.t_pulse), 0);
         chk($sformatf("t2_level_e%0d", e),   32'(if_a.level), 0);
         chk($sformatf("t2_busy_e%0d", e),    32'(if_a.busy), 32'(e >= 2 && e <= 9 && e % 2 == 0));
      end

      // 3/4: press 10 cycles, release 10+ cycles on both instances
      do_reset();
      cnt_a  = 0;
      cnt_b  = 0;
      prev_a = 1'b0;
      prev_b = 1'b0;
      for (int e = 0; e < 25; e++) begin
         raw = (e < 10);
         tick();
         if (if_a.t_pulse === 1'b1) cnt_a++;
         if (if_b.t_pulse === 1'b1) cnt_b++;
         chk($sformatf("t3_consec_a_e%0d", e), 32'(prev_a & if_a.t_pulse), 0);
         chk($sformatf("t4_consec_b_e%0d", e), 32'(prev_b & if_b.t_pulse), 0);
         prev_a = if_a.t_pulse;
         prev_b = if_b.t_pulse;
         if (e == 5)  chk("t3_press_pulse_a", 32'(if_a.t_pulse), 1);
         if (e == 5)  chk("t4_press_pulse_b", 32'(if_b.t_pulse), 1);
         if (e == 14) chk("t3_level_before_rel", 32'(if_a.level), 1);
         if (e == 15) chk("t3_level_after_rel",  32'(if_a.level), 0);
         if (e == 15) chk("t3_rel_pulse_a", 32'(if_a.t_pulse), 0);
         if (e == 15) chk("t4_rel_pulse_b", 32'(if_b.t_pulse), 1);
         if (e == 15) chk("t4_level_b", 32'(if_b.level), 0);
      end
      chk("t3_pulse_count_a", 32'(cnt_a), 1);
      chk("t4_pulse_count_b", 32'(cnt_b), 2);

      // 5: reset asserted mid-WAIT_HI, button still held afterwards
      do_reset();
      for (int e = 0; e < 3; e++) begin
         raw = 1'b1;
         tick();
      end
      chk("t5_busy_before_rst", 32'(if_a.busy), 1);
      rst_n = 1'b0;
      #1;
      chk("t5_busy_in_rst",  32'(if_a.busy), 0);
      chk("t5_pulse_in_rst", 32'(if_a.t_pulse), 0);
      chk("t5_level_in_rst", 32'(if_a.level), 0);
      tick();
      rst_n = 1'b1;
      for (int f = 0; f < 8; f++) begin
         tick();
         chk($sformatf("t5_pulse_f%0d", f), 32'(if_a.t_pulse), 32'(f == 5));
      end

      // 6: four qualified presses drive the T flip-flop through 1,0,1,0
      do_reset();
      q_seq = 4'b0101;
      for (int p = 0; p < 4; p++) begin
         for (int e = 0; e < 16; e++) begin
            raw = (e < 8);
            tick();
         end
         chk($sformatf("t6_tff_press%0d", p), 32'(tff_q), 32'(q_seq[p]));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
